// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state encoding, opcode/funct values and ALU encodings for the multi-cycle controller
// MULTI_CYCLE_BNE_EN adds the BNEEX state and the bne opcode.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`ifdef MULTI_CYCLE_BNE_EN
        ,
        BNEEX   = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTI_CYCLE_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps alu_op and the R-type funct field to the ALU function code
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALUC_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALUC_ADD;
            ALUOP_SUB: o_alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FUNCT_ADD: o_alu_control = ALUC_ADD;
                    FUNCT_SUB: o_alu_control = ALUC_SUB;
                    FUNCT_AND: o_alu_control = ALUC_AND;
                    FUNCT_OR:  o_alu_control = ALUC_OR;
                    FUNCT_SLT: o_alu_control = ALUC_SLT;
                    default:   o_alu_control = ALUC_ADD;
                endcase
            end
            default: o_alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - Moore FSM controller for a multi-cycle MIPS datapath
// MULTI_CYCLE_BNE_EN enables the bne instruction via the BNEEX state.
module multi_cycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       pc_en,
    output logic [3:0] state_o
);

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_write;
    logic       w_branch;
    logic [1:0] w_alu_op;
`ifdef MULTI_CYCLE_BNE_EN
    logic       w_branch_ne;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = FETCH;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        w_alu_op   = ALUOP_ADD;
        w_pc_write = 1'b0;
        w_branch   = 1'b0;
`ifdef MULTI_CYCLE_BNE_EN
        w_branch_ne = 1'b0;
`endif
        case (r_state)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b01;
                w_pc_write = 1'b1;
                w_next     = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JEX;
`ifdef MULTI_CYCLE_BNE_EN
                    OP_BNE:       w_next = BNEEX;
`endif
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord   = 1'b1;
                w_next = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            RTYPEEX: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = RTYPEWB;
            end
            RTYPEWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BEQEX: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_SUB;
                pc_src    = 2'b01;
                w_branch  = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = ADDIWB;
            end
            ADDIWB: reg_write = 1'b1;
            JEX: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
            end
`ifdef MULTI_CYCLE_BNE_EN
            BNEEX: begin
                alu_src_a   = 1'b1;
                w_alu_op    = ALUOP_SUB;
                pc_src      = 2'b01;
                w_branch_ne = 1'b1;
            end
`endif
            default: w_next = FETCH;
        endcase
    end

    // Branch resolution is the only Mealy-style path: zero feeds pc_en in the same cycle.
`ifdef MULTI_CYCLE_BNE_EN
    assign pc_en = w_pc_write | (w_branch & zero) | (w_branch_ne & ~zero);
`else
    assign pc_en = w_pc_write | (w_branch & zero);
`endif

    assign state_o = r_state;

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct       (funct),
        .o_alu_control (alu_control)
    );

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - directed scoreboard bench for multi_cycle_control
module tb_multi_cycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       pc_en;
    logic [3:0] state_o;

    int n_pass  = 0;
    int n_total = 0;

    string         q_tag[$];
    logic [18:0]   q_exp[$];

    multi_cycle_control dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .pc_en       (pc_en),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
    //  alu_src_b, pc_src, alu_control, pc_en}
    function automatic logic [18:0] pk(input logic [3:0] st, input logic io, input logic mw,
                                       input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] pcs, input logic [2:0] aluc,
                                       input logic pce);
        return {st, io, mw, irw, rd, m2r, rw, asa, asb, pcs, aluc, pce};
    endfunction

    function automatic logic [2:0] exp_aluc(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    localparam logic [18:0] E_FETCH  = {4'd0,  7'b0010000, 2'b01, 2'b00, 3'b010, 1'b1};
    localparam logic [18:0] E_DECODE = {4'd1,  7'b0000000, 2'b11, 2'b00, 3'b010, 1'b0};
    localparam logic [18:0] E_MEMADR = {4'd2,  7'b0000001, 2'b10, 2'b00, 3'b010, 1'b0};
    localparam logic [18:0] E_MEMRD  = {4'd3,  7'b1000000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [18:0] E_MEMWB  = {4'd4,  7'b0000110, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [18:0] E_MEMWR  = {4'd5,  7'b1100000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [18:0] E_RTWB   = {4'd7,  7'b0001010, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [18:0] E_ADDIEX = {4'd9,  7'b0000001, 2'b10, 2'b00, 3'b010, 1'b0};
    localparam logic [18:0] E_ADDIWB = {4'd10, 7'b0000010, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [18:0] E_JEX    = {4'd11, 7'b0000000, 2'b00, 2'b10, 3'b010, 1'b1};

    task automatic push(input string tag, input logic [18:0] v);
        q_tag.push_back(tag);
        q_exp.push_back(v);
    endtask

    task automatic check_one();
        string       tag;
        logic [18:0] exp_v;
        logic [18:0] obs;
        tag   = q_tag.pop_front();
        exp_v = q_exp.pop_front();
        obs   = {state_o, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                 alu_src_a, alu_src_b, pc_src, alu_control, pc_en};
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // One comparison per cycle; the last step lands on the next instruction's FETCH.
    task automatic run_all();
        while (q_exp.size() > 0) begin
            check_one();
            @(negedge clk);
        end
    endtask

    task automatic issue(input string nm, input logic [5:0] o, input logic [5:0] f, input logic z);
        op    = o;
        funct = f;
        zero  = z;
        push({nm, "/FETCH"}, E_FETCH);
        push({nm, "/DECODE"}, E_DECODE);
        case (o)
            6'b100011: begin
                push({nm, "/MEMADR"}, E_MEMADR);
                push({nm, "/MEMRD"}, E_MEMRD);
                push({nm, "/MEMWB"}, E_MEMWB);
            end
            6'b101011: begin
                push({nm, "/MEMADR"}, E_MEMADR);
                push({nm, "/MEMWR"}, E_MEMWR);
            end
            6'b000000: begin
                push({nm, "/RTYPEEX"}, pk(4'd6, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, exp_aluc(f), 0));
                push({nm, "/RTYPEWB"}, E_RTWB);
            end
            6'b000100: push({nm, "/BEQEX"}, pk(4'd8, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, z));
            6'b001000: begin
                push({nm, "/ADDIEX"}, E_ADDIEX);
                push({nm, "/ADDIWB"}, E_ADDIWB);
            end
            6'b000010: push({nm, "/JEX"}, E_JEX);
`ifdef MULTI_CYCLE_BNE_EN
            6'b000101: push({nm, "/BNEEX"}, pk(4'd12, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, ~z));
`endif
            default: ;
        endcase
        run_all();
    endtask

    initial begin
        rst   = 1'b1;
        op    = 6'b0;
        funct = 6'b0;
        zero  = 1'b0;

        #12;
        push("rst/hold", E_FETCH);
        check_one();
        #10;
        rst = 1'b0;
        #1;
        push("rst/release", E_FETCH);
        check_one();

        issue("lw",      6'b100011, 6'b000000, 1'b0);
        issue("sw",      6'b101011, 6'b000000, 1'b0);
        issue("slt",     6'b000000, 6'b101010, 1'b0);
        issue("sub",     6'b000000, 6'b100010, 1'b0);
        issue("and",     6'b000000, 6'b100100, 1'b1);
        issue("or",      6'b000000, 6'b100101, 1'b0);
        issue("add",     6'b000000, 6'b100000, 1'b0);
        issue("rt_oth",  6'b000000, 6'b111111, 1'b0);
        issue("addi",    6'b001000, 6'b000000, 1'b0);
        issue("beq_z1",  6'b000100, 6'b000000, 1'b1);
        issue("beq_z0",  6'b000100, 6'b000000, 1'b0);
        issue("j",       6'b000010, 6'b000000, 1'b0);
        issue("illegal", 6'b111111, 6'b000000, 1'b0);
        issue("bne_z0",  6'b000101, 6'b000000, 1'b0);
        issue("bne_z1",  6'b000101, 6'b000000, 1'b1);

        // Reset asserted while sitting in MEMRD must return to FETCH without a clock edge.
        op = 6'b100011;
        push("mid/FETCH", E_FETCH);
        push("mid/DECODE", E_DECODE);
        push("mid/MEMADR", E_MEMADR);
        run_all();
        push("mid/MEMRD", E_MEMRD);
        check_one();
        #2;
        rst = 1'b1;
        #1;
        push("mid/async", E_FETCH);
        check_one();
        @(negedge clk);
        push("mid/held", E_FETCH);
        check_one();
        rst = 1'b0;
        #1;
        push("mid/release", E_FETCH);
        check_one();

        issue("lw2", 6'b100011, 6'b000000, 1'b0);
        push("end/FETCH", E_FETCH);
        check_one();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
